regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
Initiator side of the RV32I register file port. Accepts writeback requests and operand-read requests on valid/ready interfaces and serialises them into single-cycle regfile commands. The register file blanks read data during write cycles, so writes and reads are never issued in the same cycle. Sits between decode/writeback and register_file; drives rf_cs/wr_en/addresses and captures qa/qb into a 1-entry response buffer.

Parameters:
REG_DATA_W, 32, data width (RV32I)
ADDR_WIDTH, 5, register index width ($clog2(32))

Ports:
rf_clk  in  1  clock
rf_ares_n  in  1  reset; one clock; reset is asynchronous and active-low
wb_valid  in  1  writeback request valid
wb_ready  out  1  writeback request accepted when wb_valid & wb_ready
wb_rd  in  ADDR_WIDTH  destination register
wb_data  in  REG_DATA_W  write data
rd_req_valid  in  1  operand read request valid
rd_req_ready  out  1  read request accepted when both high
rd_rs1  in  ADDR_WIDTH  source register A
rd_rs2  in  ADDR_WIDTH  source register B
rd_rsp_valid  out  1  response data valid
rd_rsp_ready  in  1  consumer takes response
rd_rsp_a  out  REG_DATA_W  value of rs1
rd_rsp_b  out  REG_DATA_W  value of rs2
rf_cs  out  1  regfile chip select (registered)
wr_en  out  1  regfile write enable (registered)
rw_dec  out  ADDR_WIDTH  write address (registered)
ra_dec  out  ADDR_WIDTH  read address A (registered)
rb_dec  out  ADDR_WIDTH  read address B (registered)
w_data_in  out  REG_DATA_W  write data (registered)
rf_qa  in  REG_DATA_W  regfile qa_out
rf_qb  in  REG_DATA_W  regfile qb_out

Behaviour:
- Reset: state IDLE, last_wr=0, all rf_* outputs and addresses/data 0, rd_rsp_valid=0, rd_rsp_a/b=0; wb_ready=rd_req_ready=0 while reset asserted. Reset mid-operation drops any in-flight command and buffered response.
- State = command presented to the regfile this cycle: IDLE (rf_cs=0, wr_en=0, addr/data 0), WRITE (rf_cs=1, wr_en=1, rw_dec/w_data_in latched), READ (rf_cs=1, wr_en=0, ra_dec/rb_dec latched).
- rd_ok = (state!=READ) & (~rd_rsp_valid | rd_rsp_ready).
- Arbitration each cycle: read wins if rd_req_valid & rd_ok & (last_wr | ~wb_valid); else write wins if wb_valid. rd_req_ready = read wins; wb_ready = ~(read wins). Acceptance is combinational from valid; ready never depends on own-channel data.
- Next state: WRITE on write accept, READ on read accept, else IDLE. last_wr <= 1 on a write issue, 0 on a read issue, hold in IDLE.
- Latency: write accepted at t -> WRITE at t+1 -> regfile updated at end of t+1. Read accepted at t -> READ at t+1 -> rf_qa/rf_qb captured at end of t+1 -> rd_rsp_valid at t+2.
- Throughput: back-to-back writes 1/cycle; reads 1 per 2 cycles; under contention writes and reads alternate (no starvation).
- Ordering: commands issue in acceptance order; a read accepted after a write to the same register returns the new value; no bypass needed.
- Response buffer: loads on READ-cycle end; holds stable while rd_rsp_valid & ~rd_rsp_ready; clears on rd_rsp_ready with no load.
- rd=0 writes are issued as normal (regfile discards them).

Optional Feature:
RFC_X0_SKIP_EN: defined -> write accepts with wb_rd==0 complete without a WRITE cycle (next state IDLE, last_wr unchanged); READ responses force rd_rsp_a/b to 0 where rs1/rs2==0. Undefined -> all writes issued; read data passed through unmodified.

Decomposition:
- Package rv32i_rf_pkg: REG_DATA_W, ADDR_WIDTH, REG_NUMBER constants; rfc_state_e enum {IDLE, WRITE, READ}.
- Sub-module rf_rsp_slot: 1-entry valid/ready holding register for rd_rsp_a/b.

Test Plan:
- Reset then wb rd=5 data=0xDEADBEEF at t -> t+1 rf_cs=1, wr_en=1, rw_dec=5, w_data_in=0xDEADBEEF; t+2 rf_cs=0.
- Write x5=0x1234 then read rs1=5 rs2=0 -> rd_rsp_a=0x1234, rd_rsp_b=0, valid 2 cycles after read accept.
- wb_valid and rd_req_valid held high 10 cycles -> issued pattern alternates WRITE/READ after first write; no wr_en=1 cycle coincides with READ.
- rd_rsp_ready=0 with response pending -> rd_req_ready=0, rd_rsp_a/b stable; ready=1 -> next read accepted same cycle.
- Assert rf_ares_n=0 during READ -> rf_cs, rd_rsp_valid 0 immediately; no response after release.
- RFC_X0_SKIP_EN: wb rd=0 -> wb_ready=1, no wr_en pulse; read rs1=0 with rf_qa=0xFFFFFFFF forced -> rd_rsp_a=0.

Source files
------------

// File: rtl/rv32i_rf_pkg.sv
// Shared constants and command-state encoding for the RV32I register file access path.
package rv32i_rf_pkg;

  localparam int REG_DATA_W = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_NUMBER = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } rfc_state_e;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Request/response and regfile-side signals of the register file access controller.
interface regfile_access_ctrl_if;
  import rv32i_rf_pkg::*;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [REG_DATA_W-1:0] wb_data;

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_rs1;
  logic [ADDR_WIDTH-1:0] rd_rs2;

  logic                  rd_rsp_valid;
  logic                  rd_rsp_ready;
  logic [REG_DATA_W-1:0] rd_rsp_a;
  logic [REG_DATA_W-1:0] rd_rsp_b;

  logic                  rf_cs;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] rw_dec;
  logic [ADDR_WIDTH-1:0] ra_dec;
  logic [ADDR_WIDTH-1:0] rb_dec;
  logic [REG_DATA_W-1:0] w_data_in;
  logic [REG_DATA_W-1:0] rf_qa;
  logic [REG_DATA_W-1:0] rf_qb;

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  rd_req_valid, rd_rs1, rd_rs2,
    input  rd_rsp_ready,
    input  rf_qa, rf_qb,
    output wb_ready, rd_req_ready,
    output rd_rsp_valid, rd_rsp_a, rd_rsp_b,
    output rf_cs, wr_en, rw_dec, ra_dec, rb_dec, w_data_in
  );

  modport master (
    output wb_valid, wb_rd, wb_data,
    output rd_req_valid, rd_rs1, rd_rs2,
    output rd_rsp_ready,
    output rf_qa, rf_qb,
    input  wb_ready, rd_req_ready,
    input  rd_rsp_valid, rd_rsp_a, rd_rsp_b,
    input  rf_cs, wr_en, rw_dec, ra_dec, rb_dec, w_data_in
  );

endinterface

// File: rtl/rf_rsp_slot.sv
// One-entry valid/ready holding register for the two operand values of a read response.
module rf_rsp_slot
  import rv32i_rf_pkg::*;
(
  input  logic                  rf_clk,
  input  logic                  rf_ares_n,
  input  logic                  load,
  input  logic [REG_DATA_W-1:0] load_a,
  input  logic [REG_DATA_W-1:0] load_b,
  input  logic                  take,
  output logic                  vld_p2,
  output logic [REG_DATA_W-1:0] a_p2,
  output logic [REG_DATA_W-1:0] b_p2
);

  // Stage 2: response held until the consumer takes it
  always_ff @(posedge rf_clk or negedge rf_ares_n) begin
    if (!rf_ares_n) begin
      vld_p2 <= 1'b0;
      a_p2   <= '0;
      b_p2   <= '0;
    end else if (load) begin
      vld_p2 <= 1'b1;
      a_p2   <= load_a;
      b_p2   <= load_b;
    end else if (take) begin
      vld_p2 <= 1'b0;
      a_p2   <= '0;
      b_p2   <= '0;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Serialises writeback and operand-read requests into single-cycle regfile commands.
// Optional RFC_X0_SKIP_EN: drop x0 writes without a regfile cycle and force x0 reads to zero.
module regfile_access_ctrl
  import rv32i_rf_pkg::*;
(
  input logic                  rf_clk,
  input logic                  rf_ares_n,
  regfile_access_ctrl_if.slave bus
);

  rfc_state_e            state_q;
  rfc_state_e            state_d;
  logic                  last_wr_q;
  logic                  last_wr_d;
  logic                  rd_ok;
  logic                  rd_win;
  logic                  wr_acc;
  logic                  wr_skip;
  logic [ADDR_WIDTH-1:0] rw_dec_d;
  logic [ADDR_WIDTH-1:0] ra_dec_d;
  logic [ADDR_WIDTH-1:0] rb_dec_d;
  logic [REG_DATA_W-1:0] w_data_d;
  logic                  rsp_load;
  logic [REG_DATA_W-1:0] load_a;
  logic [REG_DATA_W-1:0] load_b;
  logic                  rsp_vld;
  logic [REG_DATA_W-1:0] rsp_a;
  logic [REG_DATA_W-1:0] rsp_b;

  // Reads yield to a pending write only when the previous issue was a read, so the two alternate
  always_comb begin
    rd_ok  = (state_q != READ) && (!rsp_vld || bus.rd_rsp_ready);
    rd_win = rf_ares_n && bus.rd_req_valid && rd_ok && (last_wr_q || !bus.wb_valid);
    wr_acc = rf_ares_n && bus.wb_valid && !rd_win;
`ifdef RFC_X0_SKIP_EN
    wr_skip = wr_acc && (bus.wb_rd == '0);
`else
    wr_skip = 1'b0;
`endif
  end

  assign bus.rd_req_ready = rd_win;
  assign bus.wb_ready     = rf_ares_n && !rd_win;

  always_comb begin
    state_d   = IDLE;
    last_wr_d = last_wr_q;
    rw_dec_d  = '0;
    ra_dec_d  = '0;
    rb_dec_d  = '0;
    w_data_d  = '0;
    if (rd_win) begin
      state_d   = READ;
      last_wr_d = 1'b0;
      ra_dec_d  = bus.rd_rs1;
      rb_dec_d  = bus.rd_rs2;
    end else if (wr_acc && !wr_skip) begin
      state_d   = WRITE;
      last_wr_d = 1'b1;
      rw_dec_d  = bus.wb_rd;
      w_data_d  = bus.wb_data;
    end
  end

  // Stage 1: command presented to the regfile
  always_ff @(posedge rf_clk or negedge rf_ares_n) begin
    if (!rf_ares_n) begin
      state_q       <= IDLE;
      last_wr_q     <= 1'b0;
      bus.rf_cs     <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.rw_dec    <= '0;
      bus.ra_dec    <= '0;
      bus.rb_dec    <= '0;
      bus.w_data_in <= '0;
    end else begin
      state_q       <= state_d;
      last_wr_q     <= last_wr_d;
      bus.rf_cs     <= (state_d != IDLE);
      bus.wr_en     <= (state_d == WRITE);
      bus.rw_dec    <= rw_dec_d;
      bus.ra_dec    <= ra_dec_d;
      bus.rb_dec    <= rb_dec_d;
      bus.w_data_in <= w_data_d;
    end
  end

  always_comb begin
    rsp_load = (state_q == READ);
`ifdef RFC_X0_SKIP_EN
    load_a = (bus.ra_dec == '0) ? '0 : bus.rf_qa;
    load_b = (bus.rb_dec == '0) ? '0 : bus.rf_qb;
`else
    load_a = bus.rf_qa;
    load_b = bus.rf_qb;
`endif
  end

  rf_rsp_slot u_rsp_slot (
    .rf_clk    (rf_clk),
    .rf_ares_n (rf_ares_n),
    .load      (rsp_load),
    .load_a    (load_a),
    .load_b    (load_b),
    .take      (bus.rd_rsp_ready),
    .vld_p2    (rsp_vld),
    .a_p2      (rsp_a),
    .b_p2      (rsp_b)
  );

  assign bus.rd_rsp_valid = rsp_vld;
  assign bus.rd_rsp_a     = rsp_a;
  assign bus.rd_rsp_b     = rsp_b;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed self-checking bench for regfile_access_ctrl with a behavioural register file.
module tb_regfile_access_ctrl;

  logic rf_clk;
  logic rf_ares_n;
  logic force_qa;
  int   n_pass;
  int   n_total;

  logic [31:0] regs [32] = '{default: 32'h0};

  regfile_access_ctrl_if bus ();

  regfile_access_ctrl dut (
    .rf_clk    (rf_clk),
    .rf_ares_n (rf_ares_n),
    .bus       (bus)
  );

  initial rf_clk = 1'b0;
  always #5 rf_clk = ~rf_clk;

  // Register file: blanks read data during write cycles, ignores x0 writes
  always @(posedge rf_clk) begin
    if (bus.rf_cs && bus.wr_en && bus.rw_dec != 5'd0)
      regs[bus.rw_dec] <= bus.w_data_in;
  end

  assign bus.rf_qa = force_qa ? 32'hFFFF_FFFF :
                     (bus.rf_cs && !bus.wr_en) ? regs[bus.ra_dec] : 32'h0;
  assign bus.rf_qb = (bus.rf_cs && !bus.wr_en) ? regs[bus.rb_dec] : 32'h0;

  task automatic tick();
    @(posedge rf_clk);
    #1;
  endtask

  task automatic test_reset();
    rf_ares_n = 1'b0;
    tick();
    tick();
    n_total++; if (bus.rf_cs !== 1'b0) $display("FAIL rst_rf_cs got %0h want 0", bus.rf_cs); else n_pass++;
    n_total++; if (bus.wr_en !== 1'b0) $display("FAIL rst_wr_en got %0h want 0", bus.wr_en); else n_pass++;
    n_total++; if (bus.rw_dec !== 5'd0) $display("FAIL rst_rw_dec got %0h want 0", bus.rw_dec); else n_pass++;
    n_total++; if (bus.ra_dec !== 5'd0) $display("FAIL rst_ra_dec got %0h want 0", bus.ra_dec); else n_pass++;
    n_total++; if (bus.rb_dec !== 5'd0) $display("FAIL rst_rb_dec got %0h want 0", bus.rb_dec); else n_pass++;
    n_total++; if (bus.w_data_in !== 32'h0) $display("FAIL rst_w_data got %0h want 0", bus.w_data_in); else n_pass++;
    n_total++; if (bus.rd_rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %0h want 0", bus.rd_rsp_valid); else n_pass++;
    n_total++; if (bus.rd_rsp_a !== 32'h0) $display("FAIL rst_rsp_a got %0h want 0", bus.rd_rsp_a); else n_pass++;
    n_total++; if (bus.rd_rsp_b !== 32'h0) $display("FAIL rst_rsp_b got %0h want 0", bus.rd_rsp_b); else n_pass++;
    n_total++; if (bus.wb_ready !== 1'b0) $display("FAIL rst_wb_ready got %0h want 0", bus.wb_ready); else n_pass++;
    n_total++; if (bus.rd_req_ready !== 1'b0) $display("FAIL rst_rd_req_ready got %0h want 0", bus.rd_req_ready); else n_pass++;
    rf_ares_n = 1'b1;
    tick();
    n_total++; if (bus.wb_ready !== 1'b1) $display("FAIL post_rst_wb_ready got %0h want 1", bus.wb_ready); else n_pass++;
  endtask

  task automatic test_write();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 32'hDEAD_BEEF;
    #1;
    n_total++; if (bus.wb_ready !== 1'b1) $display("FAIL wr_ready got %0h want 1", bus.wb_ready); else n_pass++;
    tick();
    bus.wb_valid = 1'b0;
    n_total++; if (bus.rf_cs !== 1'b1) $display("FAIL wr_rf_cs got %0h want 1", bus.rf_cs); else n_pass++;
    n_total++; if (bus.wr_en !== 1'b1) $display("FAIL wr_wr_en got %0h want 1", bus.wr_en); else n_pass++;
    n_total++; if (bus.rw_dec !== 5'd5) $display("FAIL wr_rw_dec got %0h want 5", bus.rw_dec); else n_pass++;
    n_total++; if (bus.w_data_in !== 32'hDEAD_BEEF) $display("FAIL wr_w_data got %0h want deadbeef", bus.w_data_in); else n_pass++;
    tick();
    n_total++; if (bus.rf_cs !== 1'b0) $display("FAIL wr_idle_rf_cs got %0h want 0", bus.rf_cs); else n_pass++;
    n_total++; if (bus.wr_en !== 1'b0) $display("FAIL wr_idle_wr_en got %0h want 0", bus.wr_en); else n_pass++;
  endtask

  task automatic test_read_after_write();
    bus.rd_rsp_ready = 1'b1;
    bus.wb_valid     = 1'b1;
    bus.wb_rd        = 5'd5;
    bus.wb_data      = 32'h0000_1234;
    tick();
    bus.wb_valid     = 1'b0;
    bus.rd_req_valid = 1'b1;
    bus.rd_rs1       = 5'd5;
    bus.rd_rs2       = 5'd0;
    #1;
    n_total++; if (bus.rd_req_ready !== 1'b1) $display("FAIL raw_req_ready got %0h want 1", bus.rd_req_ready); else n_pass++;
    tick();
    bus.rd_req_valid = 1'b0;
    n_total++; if (bus.wr_en !== 1'b0 || bus.rf_cs !== 1'b1) $display("FAIL raw_read_cycle got cs=%0h we=%0h want cs=1 we=0", bus.rf_cs, bus.wr_en); else n_pass++;
    n_total++; if (bus.ra_dec !== 5'd5) $display("FAIL raw_ra_dec got %0h want 5", bus.ra_dec); else n_pass++;
    n_total++; if (bus.rd_rsp_valid !== 1'b0) $display("FAIL raw_early_valid got %0h want 0", bus.rd_rsp_valid); else n_pass++;
    tick();
    n_total++; if (bus.rd_rsp_valid !== 1'b1) $display("FAIL raw_valid got %0h want 1", bus.rd_rsp_valid); else n_pass++;
    n_total++; if (bus.rd_rsp_a !== 32'h0000_1234) $display("FAIL raw_rsp_a got %0h want 1234", bus.rd_rsp_a); else n_pass++;
    n_total++; if (bus.rd_rsp_b !== 32'h0) $display("FAIL raw_rsp_b got %0h want 0", bus.rd_rsp_b); else n_pass++;
    tick();
    n_total++; if (bus.rd_rsp_valid !== 1'b0) $display("FAIL raw_taken got %0h want 0", bus.rd_rsp_valid); else n_pass++;
  endtask

  task automatic test_contention();
    bus.rd_rsp_ready = 1'b1;
    bus.wb_valid     = 1'b1;
    bus.rd_req_valid = 1'b1;
    bus.wb_rd        = 5'd7;
    bus.rd_rs1       = 5'd7;
    bus.rd_rs2       = 5'd5;
    for (int i = 0; i < 10; i++) begin
      bus.wb_data = 32'hA000_0000 + i;
      tick();
      n_total++;
      if (bus.rf_cs !== 1'b1 || bus.wr_en !== ((i % 2) == 0))
        $display("FAIL contend_cycle%0d got cs=%0h we=%0h want cs=1 we=%0h", i, bus.rf_cs, bus.wr_en, ((i % 2) == 0));
      else
        n_pass++;
    end
    bus.wb_valid     = 1'b0;
    bus.rd_req_valid = 1'b0;
    tick();
    tick();
    n_total++; if (regs[7] !== 32'hA000_0008) $display("FAIL contend_last_write got %0h want a0000008", regs[7]); else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.rd_rsp_ready = 1'b0;
    bus.rd_req_valid = 1'b1;
    bus.rd_rs1       = 5'd5;
    bus.rd_rs2       = 5'd0;
    tick();
    bus.rd_req_valid = 1'b0;
    tick();
    n_total++; if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_a !== 32'h0000_1234) $display("FAIL bp_first got v=%0h a=%0h want v=1 a=1234", bus.rd_rsp_valid, bus.rd_rsp_a); else n_pass++;
    bus.rd_req_valid = 1'b1;
    bus.rd_rs1       = 5'd7;
    #1;
    n_total++; if (bus.rd_req_ready !== 1'b0) $display("FAIL bp_blocked got %0h want 0", bus.rd_req_ready); else n_pass++;
    tick();
    n_total++; if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_a !== 32'h0000_1234) $display("FAIL bp_hold got v=%0h a=%0h want v=1 a=1234", bus.rd_rsp_valid, bus.rd_rsp_a); else n_pass++;
    n_total++; if (bus.rd_req_ready !== 1'b0) $display("FAIL bp_still_blocked got %0h want 0", bus.rd_req_ready); else n_pass++;
    bus.rd_rsp_ready = 1'b1;
    #1;
    n_total++; if (bus.rd_req_ready !== 1'b1) $display("FAIL bp_release got %0h want 1", bus.rd_req_ready); else n_pass++;
    tick();
    bus.rd_req_valid = 1'b0;
    n_total++; if (bus.ra_dec !== 5'd7 || bus.rd_rsp_valid !== 1'b0) $display("FAIL bp_next_read got ra=%0h v=%0h want ra=7 v=0", bus.ra_dec, bus.rd_rsp_valid); else n_pass++;
    tick();
    n_total++; if (bus.rd_rsp_a !== 32'hA000_0008) $display("FAIL bp_second_a got %0h want a0000008", bus.rd_rsp_a); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.rd_rsp_ready = 1'b1;
    bus.rd_req_valid = 1'b1;
    bus.rd_rs1       = 5'd5;
    bus.rd_rs2       = 5'd7;
    tick();
    bus.rd_req_valid = 1'b0;
    n_total++; if (bus.rf_cs !== 1'b1) $display("FAIL mid_pre_cs got %0h want 1", bus.rf_cs); else n_pass++;
    rf_ares_n = 1'b0;
    #1;
    n_total++; if (bus.rf_cs !== 1'b0) $display("FAIL mid_rf_cs got %0h want 0", bus.rf_cs); else n_pass++;
    n_total++; if (bus.rd_rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid got %0h want 0", bus.rd_rsp_valid); else n_pass++;
    tick();
    rf_ares_n = 1'b1;
    tick();
    n_total++; if (bus.rd_rsp_valid !== 1'b0 || bus.rf_cs !== 1'b0) $display("FAIL mid_after got v=%0h cs=%0h want 0 0", bus.rd_rsp_valid, bus.rf_cs); else n_pass++;
    tick();
    n_total++; if (bus.rd_rsp_valid !== 1'b0) $display("FAIL mid_late_rsp got %0h want 0", bus.rd_rsp_valid); else n_pass++;
  endtask

  task automatic test_x0();
    logic        exp_we;
    logic [31:0] exp_a;
`ifdef RFC_X0_SKIP_EN
    exp_we = 1'b0;
    exp_a  = 32'h0;
`else
    exp_we = 1'b1;
    exp_a  = 32'hFFFF_FFFF;
`endif
    bus.rd_rsp_ready = 1'b1;
    bus.wb_valid     = 1'b1;
    bus.wb_rd        = 5'd0;
    bus.wb_data      = 32'h0000_0055;
    #1;
    n_total++; if (bus.wb_ready !== 1'b1) $display("FAIL x0_wb_ready got %0h want 1", bus.wb_ready); else n_pass++;
    tick();
    bus.wb_valid = 1'b0;
    n_total++; if (bus.wr_en !== exp_we || bus.rf_cs !== exp_we) $display("FAIL x0_write_cycle got cs=%0h we=%0h want %0h", bus.rf_cs, bus.wr_en, exp_we); else n_pass++;
    bus.rd_req_valid = 1'b1;
    bus.rd_rs1       = 5'd0;
    bus.rd_rs2       = 5'd5;
    force_qa         = 1'b1;
    #1;
    n_total++; if (bus.rd_req_ready !== 1'b1) $display("FAIL x0_req_ready got %0h want 1", bus.rd_req_ready); else n_pass++;
    tick();
    bus.rd_req_valid = 1'b0;
    tick();
    force_qa = 1'b0;
    n_total++; if (bus.rd_rsp_valid !== 1'b1) $display("FAIL x0_valid got %0h want 1", bus.rd_rsp_valid); else n_pass++;
    n_total++; if (bus.rd_rsp_a !== exp_a) $display("FAIL x0_rsp_a got %0h want %0h", bus.rd_rsp_a, exp_a); else n_pass++;
    n_total++; if (bus.rd_rsp_b !== 32'h0000_1234) $display("FAIL x0_rsp_b got %0h want 1234", bus.rd_rsp_b); else n_pass++;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass           = 0;
    n_total          = 0;
    force_qa         = 1'b0;
    rf_ares_n        = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_rd        = 5'd0;
    bus.wb_data      = 32'h0;
    bus.rd_req_valid = 1'b0;
    bus.rd_rs1       = 5'd0;
    bus.rd_rs2       = 5'd0;
    bus.rd_rsp_ready = 1'b1;
    test_reset();
    test_write();
    test_read_after_write();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_x0();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
